// File: rtl/mem_map_pkg.sv
// Address map and register layout shared by the data-memory responder and its helpers.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  // Word offset inside the 16-byte MMIO page (addr[3:2]).
  typedef enum logic [1:0] {
    OffCycle  = 2'd0,
    OffTxdata = 2'd1,
    OffStatus = 2'd2,
    OffDrops  = 2'd3
  } mmio_off_e;

  localparam int unsigned EMPTY_BIT = 0;
  localparam int unsigned FULL_BIT  = 1;
  localparam int unsigned COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; invalid pushes/pops are ignored internally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Cw = Aw + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [Aw-1:0]    wr_q, rd_q;
  logic [Cw-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == Cw'(DEPTH));
  assign count_o = count_q;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + Aw'(1);
      if (do_pop)  rd_q <= rd_q + Aw'(1);
      if (do_push && !do_pop)      count_q <= count_q + Cw'(1);
      else if (do_pop && !do_push) count_q <= count_q - Cw'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !reset_i) mem_q[wr_q] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle core: word RAM plus a 16-byte MMIO page
// holding a cycle counter, a TX byte FIFO, status and drop-count registers.
module dmem_mmio
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  input  logic        enable_wmem_i,
  output logic [31:0] read_data_o32,
  output logic [7:0]  tx_data_o8,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram_q [RAM_WORDS];
  logic [RamAw-1:0] ram_idx;
  logic             is_mmio;
  mmio_off_e        off;
  logic             st_ram, st_cycle, st_tx, st_drops;

  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      drops_q, drops_d;
  logic [31:0]      status;

  logic             tx_full, tx_empty, tx_pop, tx_drop;
  logic [CntW-1:0]  tx_count;

  logic             unused_addr;
  assign unused_addr = ^addr_i32[1:0];

  assign is_mmio = (addr_i32[31:4] == MMIO_BASE[31:4]);
  assign off     = mmio_off_e'(addr_i32[3:2]);
  assign ram_idx = addr_i32[RamAw+1:2];

  assign st_ram   = enable_wmem_i && !is_mmio;
  assign st_cycle = enable_wmem_i && is_mmio && (off == OffCycle);
  assign st_tx    = enable_wmem_i && is_mmio && (off == OffTxdata);
  assign st_drops = enable_wmem_i && is_mmio && (off == OffDrops);

  always_ff @(posedge clk_i) begin
    if (st_ram) ram_q[ram_idx] <= write_data_i32;
  end

  // The store cycle itself counts, so the cycle after a store already reads value+1.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (st_cycle) cycle_d = write_data_i32 + 32'd1;
  end

  assign tx_valid_o = !tx_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign tx_drop    = st_tx && tx_full && !tx_pop;

  always_comb begin
    drops_d = drops_q;
    if (st_drops) begin
      drops_d = '0;
    end else if (tx_drop && (drops_q != 32'hFFFF_FFFF)) begin
      drops_d = drops_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_q <= '0;
      drops_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      drops_q <= drops_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (st_tx),
    .data_i  (write_data_i32[7:0]),
    .pop_i   (tx_ready_i),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (tx_data_o8)
  );

  always_comb begin
    status                  = '0;
    status[COUNT_LSB +: 8]  = 8'(tx_count);
    status[FULL_BIT]        = tx_full;
    status[EMPTY_BIT]       = tx_empty;
  end

  always_comb begin
    read_data_o32 = ram_q[ram_idx];
    if (is_mmio) begin
      unique case (off)
        OffCycle:  read_data_o32 = cycle_q;
        OffTxdata: read_data_o32 = '0;
        OffStatus: read_data_o32 = status;
        OffDrops:  read_data_o32 = drops_q;
        default:   read_data_o32 = '0;
      endcase
    end
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Responder for the MIPS core's data-memory interface: data RAM, plus a small memory-mapped I/O page.
- Serves loads combinationally (same cycle), as the single-cycle core requires.
- Commits stores on the rising clock edge.
- MMIO page holds a free-running cycle counter, a byte output FIFO drained over a valid/ready stream, and status/drop registers.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 2, at most 128.
- MMIO_BASE, 32'hFFFF_0000, base address of the 16-byte MMIO page.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- addr_i32  in  32  byte address (core ALU result).
- write_data_i32  in  32  store data.
- enable_wmem_i  in  1  store strobe; sampled at posedge.
- read_data_o32  out  32  load data; combinational from addr_i32 and current state.
- tx_data_o8  out  8  FIFO head byte.
- tx_valid_o  out  1  FIFO non-empty.
- tx_ready_i  in  1  sink accepts the head byte this cycle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, reset_i).
- Decode:
  - addr_i32[31:4] == MMIO_BASE[31:4] selects MMIO.
  - Otherwise RAM, at word index addr_i32[$clog2(RAM_WORDS)+1:2]; upper bits are ignored (aliasing).
  - addr_i32[1:0] is ignored everywhere; no misalignment fault.
- RAM:
  - Asynchronous read.
  - Write at posedge when enable_wmem_i is high.
  - Contents are not cleared by reset.
- MMIO map (offset = addr_i32[3:2]):
  - 0 CYCLE: read returns counter. Counter increments every cycle and wraps 2^32-1 -> 0. A store loads write_data_i32; the store wins over the increment, and the next cycle reads that value +1.
  - 1 TXDATA: store pushes write_data_i32[7:0]. Read returns 0.
  - 2 STATUS: read returns {16'b0, count[7:0], 6'b0, full, empty}. Stores are ignored.
  - 3 DROPS: read returns the 32-bit count of pushes rejected while full. Any store clears it to 0. It saturates at 32'hFFFF_FFFF.
- FIFO:
  - Pop when tx_valid_o && tx_ready_i.
  - Push when enable_wmem_i, the address hits TXDATA, and (!full or pop in the same cycle).
  - Push while full without a pop: byte discarded, DROPS increments.
  - Simultaneous push and pop when full: both occur, count unchanged, no drop.
  - Simultaneous push and pop when empty: the pop cannot occur (valid low); the push lands, count becomes 1.
  - tx_data_o8 is the head entry. It is stable while tx_valid_o && !tx_ready_i.
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH; full = (count == FIFO_DEPTH); empty = (count == 0).
- STATUS reads reflect state before the current cycle's edge. A store and a load cannot coincide, because the core issues one access per cycle.
- Reset values: counter 0, FIFO empty (tx_valid_o 0, count 0), DROPS 0.
  - tx_data_o8 is don't-care while tx_valid_o is 0; drive 0 after reset.
  - read_data_o32 follows decode: RAM content, or MMIO values above.
- Reset asserted mid-stream: the FIFO flushes at that edge, and no pop is counted even if tx_ready_i is high. RAM is untouched.
- Interface stability: with tx_valid_o high, the sink may hold tx_ready_i low indefinitely with no loss. tx_valid_o never drops without a pop or a reset.

Decomposition:
- Package mem_map_pkg holds:
  - MMIO_BASE default;
  - offset enum (CYCLE=0, TXDATA=1, STATUS=2, DROPS=3);
  - STATUS bit positions (EMPTY_BIT=0, FULL_BIT=1, COUNT_LSB=8).
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/count/head) instantiated once for TX.
- RAM, counter, decode and DROPS stay in dmem_mmio.

Test Plan:
- RAM: store 32'hDEADBEEF at 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 -> both read 32'hDEADBEEF; load 0x0000_0110 with RAM_WORDS=64 -> aliases to the same word.
- Counter:
  - Release reset; after 5 cycles, load 0xFFFF_0000 -> 5.
  - Store 32'hFFFF_FFFE to CYCLE; next two cycles read FFFF_FFFF, then 0 (wrap).
- FIFO order: tx_ready_i=0, push 0x41,0x42,0x43 -> STATUS = 32'h0000_0300. Then ready=1 -> tx_data_o8 emits 41,42,43 on consecutive cycles, then tx_valid_o=0 and STATUS=32'h0000_0001.
- Overflow: FIFO_DEPTH=8, ready=0, push 10 bytes -> STATUS=32'h0000_0802, DROPS=2, first 8 bytes retained in order. Store to DROPS -> DROPS reads 0.
- Full with simultaneous push+pop: FIFO full, ready=1, push 0x5A -> count stays 8, DROPS unchanged, 0x5A is the last byte drained.
- Reset mid-stream: 4 bytes queued, ready=1, assert reset_i one cycle -> tx_valid_o=0 next cycle, STATUS=1, CYCLE=0; RAM word written before reset still reads back.
